// File: rtl/ds_ex_pipe_pkg.sv
// ds_ex_pipe_pkg
// Shared types for the ID->EX pipeline slice. The packed bundle struct mirrors
// the bit layout in pipeline.vh field for field, so a struct value can be
// driven straight onto the flat ds_ex_reg_data port.
package ds_ex_pipe_pkg;

`include "pipeline.vh"

  localparam int ID_DATA_W = `ID_DATA;

  typedef struct packed {
    logic                    mem_write;
    logic                    mem_read;
    logic                    reg_write;
    logic [`ID_M2R_W-1:0]    mem_to_reg;
    logic [`ID_MODE_W-1:0]   mem_mode;
    logic                    mem_read_us;
    logic [`ID_OPC_W-1:0]    op_control;
    logic [`ID_XLEN-1:0]     data1;
    logic [`ID_XLEN-1:0]     data2;
    logic [`ID_RD_W-1:0]     rd;
  } id_bundle_t;

endpackage

// File: rtl/ds_load_use_detect.sv
// ds_load_use_detect
// Purely combinational load-use hazard detector. Flags a hazard when the
// instruction held for EX is a valid load that writes a non-zero rd, and the
// decoding instruction actually reads that register through rs1 or rs2.
// Ports:
//   ex_valid_i, ex_mem_read_i, ex_reg_write_i, ex_rd_i : held ID/EX instruction
//   rs1_i, rs2_i, rs1_used_i, rs2_used_i              : decoding instruction sources
//   hz_o                                              : hazard present
module ds_load_use_detect
  import ds_ex_pipe_pkg::*;
#(
  parameter int RD_W = 5
) (
  input  logic            ex_valid_i,
  input  logic            ex_mem_read_i,
  input  logic            ex_reg_write_i,
  input  logic [RD_W-1:0] ex_rd_i,
  input  logic [RD_W-1:0] rs1_i,
  input  logic [RD_W-1:0] rs2_i,
  input  logic            rs1_used_i,
  input  logic            rs2_used_i,
  output logic            hz_o
);

  logic [2*RD_W-1:0] rs_flat;
  logic [1:0]        used;
  logic [1:0]        src_hit;
  logic              ex_is_load_wb;

  assign rs_flat = {rs2_i, rs1_i};
  assign used    = {rs2_used_i, rs1_used_i};

  // A source only matters when the instruction really reads it; an unused
  // field may carry arbitrary immediate bits.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = used[gi] & (rs_flat[gi*RD_W +: RD_W] == ex_rd_i);
    end
  endgenerate

  // x0 is hardwired, so a load targeting it never produces a dependency.
  assign ex_is_load_wb = ex_valid_i & ex_mem_read_i & ex_reg_write_i & (|ex_rd_i);
  assign hz_o          = ex_is_load_wb & (|src_hit);

endmodule

// File: rtl/pipeline.vh
// Shared ID->EX bundle layout.
// Both the decode-side producer (ds_ex_pipe) and the EX-side unpacking include
// this file, so the two ends of the interface always agree on field placement.
// Bundle, MSB -> LSB:
//   {MemWrite, MemRead, RegWrite, MemtoReg[3:0], Mem_mode[2:0], Mem_read_us,
//    OpControl[10:0], data1[31:0], data2[31:0], rd[4:0]}  = 91 bits
`ifndef PIPELINE_VH
`define PIPELINE_VH

`define ID_RD_W          5
`define ID_XLEN          32
`define ID_M2R_W         4
`define ID_MODE_W        3
`define ID_OPC_W         11

`define ID_RD_LSB        0
`define ID_DATA2_LSB     5
`define ID_DATA1_LSB     37
`define ID_OPC_LSB       69
`define ID_RUS_BIT       80
`define ID_MODE_LSB      81
`define ID_M2R_LSB       84
`define ID_REGWRITE_BIT  88
`define ID_MEMREAD_BIT   89
`define ID_MEMWRITE_BIT  90

`define ID_DATA          91

`endif

// File: rtl/ds_ex_pipe.sv
// ds_ex_pipe
// Decode-side producer of the ID->EX interface: packs decoded control and
// operands into the ID/EX pipeline register, runs the valid/allowin handshake
// toward EX, honours branch flushes and inserts one bubble per load-use hazard.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   ds_*              : decoded instruction fields and valid from decode
//   es_allowin        : EX can accept this cycle
//   flush             : redirect; kills whatever is entering EX
//   ds_allowin        : decode may advance
//   ds_ex_reg_valid   : bundle valid toward EX
//   ds_ex_reg_data    : packed bundle (layout in pipeline.vh)
//   load_use_stall    : hazard bubble this cycle
//   bubble_cnt        : bubble counter, only with DS_EX_PERF_CNT_EN defined
// Optional feature macro: DS_EX_PERF_CNT_EN (adds bubble_cnt).
`include "pipeline.vh"

module ds_ex_pipe
  import ds_ex_pipe_pkg::*;
#(
  parameter int RD_W = 5,
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ds_valid,
  input  logic                ds_MemWrite,
  input  logic                ds_MemRead,
  input  logic                ds_RegWrite,
  input  logic [3:0]          ds_MemtoReg,
  input  logic [2:0]          ds_Mem_mode,
  input  logic                ds_Mem_read_us,
  input  logic [10:0]         ds_OpControl,
  input  logic [XLEN-1:0]     ds_data1,
  input  logic [XLEN-1:0]     ds_data2,
  input  logic [RD_W-1:0]     ds_rd,
  input  logic [RD_W-1:0]     ds_rs1,
  input  logic [RD_W-1:0]     ds_rs2,
  input  logic                ds_rs1_used,
  input  logic                ds_rs2_used,
  input  logic                es_allowin,
  input  logic                flush,
  output logic                ds_allowin,
  output logic                ds_ex_reg_valid,
  output logic [`ID_DATA-1:0] ds_ex_reg_data,
`ifdef DS_EX_PERF_CNT_EN
  output logic [31:0]         bubble_cnt,
`endif
  output logic                load_use_stall
);

  logic       valid_q, valid_d;
  id_bundle_t data_q, data_d, data_in;
  logic       hz;
  logic       ds_ready_go;
  logic       ds_to_es;

  always_comb begin
    data_in             = '0;
    data_in.mem_write   = ds_MemWrite;
    data_in.mem_read    = ds_MemRead;
    data_in.reg_write   = ds_RegWrite;
    data_in.mem_to_reg  = ds_MemtoReg;
    data_in.mem_mode    = ds_Mem_mode;
    data_in.mem_read_us = ds_Mem_read_us;
    data_in.op_control  = ds_OpControl;
    data_in.data1       = ds_data1;
    data_in.data2       = ds_data2;
    data_in.rd          = ds_rd;
  end

  ds_load_use_detect #(
    .RD_W (RD_W)
  ) u_detect (
    .ex_valid_i     (valid_q),
    .ex_mem_read_i  (data_q.mem_read),
    .ex_reg_write_i (data_q.reg_write),
    .ex_rd_i        (data_q.rd),
    .rs1_i          (ds_rs1),
    .rs2_i          (ds_rs2),
    .rs1_used_i     (ds_rs1_used),
    .rs2_used_i     (ds_rs2_used),
    .hz_o           (hz)
  );

  assign ds_ready_go    = ~hz;
  assign ds_allowin     = ~ds_valid | (ds_ready_go & es_allowin);
  assign ds_to_es       = ds_valid & ds_ready_go & es_allowin;
  assign load_use_stall = ds_valid & hz;

  // Flush kills the slot even when EX is stalled; the payload is left alone
  // since a cleared valid already makes it dead. On a hazard with EX ready,
  // ds_to_es is low so a bubble (valid=0) is written and decode holds.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (es_allowin) begin
      valid_d = ds_to_es;
      if (ds_to_es) begin
        data_d = data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign ds_ex_reg_valid = valid_q;
  assign ds_ex_reg_data  = data_q;

`ifdef DS_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Count only bubbles that actually land in the register: a flush or an
  // EX stall in the same cycle means no bubble was inserted.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (load_use_stall & es_allowin & ~flush) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/ds_ex_pipe.md
Name: ds_ex_pipe

Overview:
- Decode-side producer of the ID→EX interface.
- Packs decoded control and operand fields into the ds_ex_reg_data bundle and holds them in the ID/EX pipeline register.
- Drives a valid/allowin handshake toward EX and accepts branch flushes.
- Detects load-use hazards against the instruction currently held for EX, and inserts one bubble per hazard.

Parameters:
- RD_W, 5, register index width.
- XLEN, 32, operand width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- ds_valid  in  1  decode holds a valid instruction
- ds_MemWrite  in  1  store
- ds_MemRead  in  1  load
- ds_RegWrite  in  1  writes rd
- ds_MemtoReg  in  4  writeback select
- ds_Mem_mode  in  3  access size
- ds_Mem_read_us  in  1  unsigned load
- ds_OpControl  in  11  ALU control
- ds_data1  in  XLEN  operand 1
- ds_data2  in  XLEN  operand 2
- ds_rd  in  RD_W  destination
- ds_rs1, ds_rs2  in  RD_W  sources
- ds_rs1_used, ds_rs2_used  in  1  source actually read
- es_allowin  in  1  EX can accept this cycle
- flush  in  1  redirect; kill the instruction being passed into EX
- ds_allowin  out  1  decode may advance
- ds_ex_reg_valid  out  1  bundle valid to EX
- ds_ex_reg_data  out  `ID_DATA  bundle, MSB→LSB: {MemWrite, MemRead, RegWrite, MemtoReg, Mem_mode, Mem_read_us, OpControl, data1, data2, rd}; width 91
- load_use_stall  out  1  hazard bubble this cycle

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is synchronous, active-high.
  - On rst: ds_ex_reg_valid=0, ds_ex_reg_data=0, perf counter=0.
- Hazard (combinational): hz = ds_ex_reg_valid & MemRead_q & RegWrite_q & (rd_q!=0) & ((ds_rs1_used & ds_rs1==rd_q) | (ds_rs2_used & ds_rs2==rd_q)).
  - load_use_stall = ds_valid & hz.
  - ds_ready_go = ~hz.
- Handshake signals:
  - ds_allowin = ~ds_valid | (ds_ready_go & es_allowin).
  - ds_to_es = ds_valid & ds_ready_go & es_allowin.
- Register update, per posedge, in priority order:
  1. rst: clear.
  2. flush: valid←0; data unchanged.
  3. es_allowin: valid←ds_to_es; data←packed inputs only when ds_to_es.
  4. Otherwise hold valid and data.
- Latency: 1 cycle from ds_to_es to ds_ex_reg_valid.
- Bubble behaviour:
  - On a hazard with es_allowin=1, valid←0 (bubble) and decode holds.
  - Next cycle the load has left the register, so hz=0 and the instruction advances.
  - Stall is exactly 1 cycle when EX is not backpressured.
- es_allowin=0: register frozen and valid held. ds_allowin=0 while ds_valid=1.
- flush and ds_to_es in the same cycle: flush wins and the incoming instruction is dropped.
- flush and es_allowin=0 in the same cycle: valid still cleared.
- rd=0 loads never cause a stall.
- An unused source field matching rd_q never causes a stall.
- rst asserted mid-stall: the register clears; the next cycle has no hazard.

Optional Feature:
- Macro: DS_EX_PERF_CNT_EN.
- Defined: adds output bubble_cnt [31:0]. The counter increments on each edge where load_use_stall & es_allowin & ~flush; it wraps from 0xFFFFFFFF to 0 and clears on rst.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- pipeline.vh (shared): `ID_DATA width and per-field offset/width macros, shared with EX's unpacking so both ends agree.
- One sub-module: ds_load_use_detect (pure combinational hz logic).
- The register, handshake and counter stay in ds_ex_pipe.

Test Plan:
- Plain flow: ds_valid=1, es_allowin=1, data1=0x11, data2=0x22, rd=5, OpControl=0x001 → next cycle valid=1, bundle[36:5]=0x22, rd field=5, data1 field=0x11.
- Backpressure: valid=1 held, es_allowin=0 for 3 cycles with new decode inputs → bundle unchanged, ds_allowin=0. Release → new instruction loaded.
- Load-use: lw x7 in register, next instruction reads rs1=7 (rs1_used=1) → load_use_stall=1 for 1 cycle, bubble (valid=0), then the instruction passes. bubble_cnt=1 when DS_EX_PERF_CNT_EN is defined.
- No false stall: held load with rd=0, or rs2=7 with rs2_used=0 → no stall.
- Flush: flush=1 while ds_to_es=1 → valid=0 next cycle; data unchanged.
- Reset: rst=1 during an active stall → valid=0, data=0, counter=0 after 1 edge.
